// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a 16-bit asynchronous SRAM: each 32-bit access runs as
// a low-half phase then a high-half phase, then a one-cycle acknowledge.
module sram_arbiter #(
    parameter int unsigned PHASE      = 2,
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [17:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_rw,
    input  logic [17:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_dout,
    input  logic [15:0] ram_din,
    output logic        ram_doe,
    output logic        ram_wre,
    output logic        ram_oe,
    output logic        busy
);

    localparam int unsigned CW  = $clog2(MAX_CONSEC + 1);
    localparam int unsigned PW  = $clog2(PHASE);
    localparam int unsigned PW1 = PW + 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t        state;
    logic [CW-1:0] consec;
    logic [PW-1:0] pcnt;
    logic          owner_mem;
    logic          rw;
    logic [16:0]   word_addr;
    logic [15:0]   wdata_hi;

    logic          grant_if;
    logic [17:0]   sel_addr;
    logic          sel_rw;
    logic          last;
    logic [PW:0]   pnext;
    logic          unused_bits;

    // MEM wins unless IF has waited out MAX_CONSEC consecutive MEM grants
    assign grant_if    = if_req && (!mem_req || consec == CW'(MAX_CONSEC));
    assign sel_addr    = grant_if ? if_addr : mem_addr;
    assign sel_rw      = !grant_if && mem_rw;
    assign last        = pcnt == PW'(PHASE - 1);
    assign pnext       = {1'b0, pcnt} + PW1'(1);
    assign unused_bits = sel_addr[0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            consec    <= '0;
            pcnt      <= '0;
            owner_mem <= 1'b0;
            rw        <= 1'b0;
            word_addr <= '0;
            wdata_hi  <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            ram_addr  <= '0;
            ram_dout  <= '0;
            ram_doe   <= 1'b0;
            ram_wre   <= 1'b1;
            ram_oe    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || mem_req) begin
                        state     <= LO;
                        busy      <= 1'b1;
                        pcnt      <= '0;
                        owner_mem <= !grant_if;
                        rw        <= sel_rw;
                        word_addr <= sel_addr[17:1];
                        wdata_hi  <= mem_wdata[31:16];
                        ram_addr  <= {sel_addr[17:1], 1'b0};
                        ram_dout  <= mem_wdata[15:0];
                        ram_doe   <= sel_rw;
                        ram_oe    <= sel_rw;
                        ram_wre   <= !sel_rw;
                        if (grant_if || !if_req) begin
                            consec <= '0;
                        end else if (consec != CW'(MAX_CONSEC)) begin
                            consec <= consec + CW'(1);
                        end
                    end
                end
                LO, HI: begin
                    if (last) begin
                        pcnt <= '0;
                        if (!rw) begin
                            if (owner_mem) begin
                                if (state == LO) mem_rdata[15:0]  <= ram_din;
                                else             mem_rdata[31:16] <= ram_din;
                            end else begin
                                if (state == LO) if_rdata[15:0]   <= ram_din;
                                else             if_rdata[31:16]  <= ram_din;
                            end
                        end
                        if (state == LO) begin
                            state    <= HI;
                            ram_addr <= {word_addr, 1'b1};
                            ram_dout <= wdata_hi;
                            ram_wre  <= !rw;
                        end else begin
                            state   <= DONE;
                            ram_wre <= 1'b1;
                            ram_oe  <= 1'b1;
                            ram_doe <= 1'b0;
                            if_ack  <= !owner_mem;
                            mem_ack <= owner_mem;
                        end
                    end else begin
                        // write strobe stays low until the final hold cycle of the phase
                        pcnt    <= pcnt + PW'(1);
                        ram_wre <= !(rw && (pnext < PW1'(PHASE - 1)));
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed table, hand sequences for arbitration/reset corners,
// randomized traffic against a transaction-level model, and a PHASE=3 instance.
module tb_sram_arbiter;

    localparam int P    = 2;
    localparam int MAXC = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, mem_req, mem_rw;
    logic [17:0] if_addr, mem_addr;
    logic [31:0] mem_wdata;
    logic        if_ack, mem_ack, ram_doe, ram_wre, ram_oe, busy;
    logic [31:0] if_rdata, mem_rdata;
    logic [17:0] ram_addr;
    logic [15:0] ram_dout, ram_din;

    logic        p3_mem_req, p3_mem_rw;
    logic [17:0] p3_mem_addr;
    logic [31:0] p3_mem_wdata;
    logic        p3_if_ack, p3_mem_ack, p3_ram_doe, p3_ram_wre, p3_ram_oe, p3_busy;
    logic [31:0] p3_if_rdata, p3_mem_rdata;
    logic [17:0] p3_ram_addr;
    logic [15:0] p3_ram_dout, p3_ram_din;

    logic [15:0] sram    [0:262143];
    logic [15:0] ref_mem [0:262143];
    logic [15:0] sram3   [0:255];
    logic        pre_we;
    logic [17:0] pre_a;
    logic [15:0] pre_d;

    int          checks = 0, failures = 0, cyc = 0;
    int          consec_m;
    logic [31:0] exp_if_rd, exp_mem_rd;
    int          last_if_ack, last_mem_ack;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // board SRAM models: asynchronous read, write while the strobe is low
    always @(posedge clock) begin
        if (pre_we) sram[pre_a] <= pre_d;
        else if (!ram_wre && ram_doe) sram[ram_addr] <= ram_dout;
    end
    assign ram_din = ram_oe ? 16'h0000 : sram[ram_addr];

    always @(posedge clock) if (!p3_ram_wre && p3_ram_doe) sram3[p3_ram_addr[7:0]] <= p3_ram_dout;
    assign p3_ram_din = p3_ram_oe ? 16'h0000 : sram3[p3_ram_addr[7:0]];

    sram_arbiter #(.PHASE(P), .MAX_CONSEC(MAXC)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
        .ram_doe(ram_doe), .ram_wre(ram_wre), .ram_oe(ram_oe), .busy(busy)
    );

    sram_arbiter #(.PHASE(3), .MAX_CONSEC(MAXC)) dut3 (
        .clock(clock), .reset(reset),
        .if_req(1'b0), .if_addr(18'h0), .if_ack(p3_if_ack), .if_rdata(p3_if_rdata),
        .mem_req(p3_mem_req), .mem_rw(p3_mem_rw), .mem_addr(p3_mem_addr), .mem_wdata(p3_mem_wdata),
        .mem_ack(p3_mem_ack), .mem_rdata(p3_mem_rdata),
        .ram_addr(p3_ram_addr), .ram_dout(p3_ram_dout), .ram_din(p3_ram_din),
        .ram_doe(p3_ram_doe), .ram_wre(p3_ram_wre), .ram_oe(p3_ram_oe), .busy(p3_busy)
    );

    typedef struct {
        logic        is_if;
        logic        rw;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] init_val(input int i);
        if (i == 16) return 16'h5678;
        if (i == 17) return 16'h1234;
        return 16'(i * 40503 + 7);
    endfunction

    // One access starting in the current IDLE cycle; the expected winner, addresses,
    // strobes and data come from the arbitration rules and the word-level memory.
    task automatic transact(output logic won_if, output logic [31:0] got);
        logic        gi, wr;
        logic [17:0] a;
        logic [31:0] wd, rd;
        int          wlo, ph;
        gi = if_req && (!mem_req || consec_m == MAXC);
        a  = gi ? if_addr : mem_addr;
        a[0] = 1'b0;
        wr = !gi && mem_rw;
        wd = mem_wdata;
        wlo = 0;
        got = 32'h0;
        if (gi || !if_req) consec_m = 0;
        else if (consec_m < MAXC) consec_m++;
        if (wr) begin
            ref_mem[a] = wd[15:0];
            ref_mem[a | 18'd1] = wd[31:16];
        end else begin
            rd = {ref_mem[a | 18'd1], ref_mem[a]};
            if (gi) exp_if_rd = rd;
            else    exp_mem_rd = rd;
        end
        for (int c = 1; c <= 2 * P + 1; c++) begin
            tick();
            if (c <= 2 * P) begin
                ph = (c - 1) / P;
                chk("busy_access", 32'(busy), 32'd1);
                chk("ack_early", 32'({if_ack, mem_ack}), 32'd0);
                chk("ram_addr", 32'(ram_addr), 32'(a | 18'(ph)));
                chk("ram_oe", 32'(ram_oe), 32'(wr));
                chk("ram_doe", 32'(ram_doe), 32'(wr));
                if (wr) chk("ram_dout", 32'(ram_dout), 32'((ph != 0) ? wd[31:16] : wd[15:0]));
                if (!ram_wre) wlo++;
                if (c % P == 0) begin
                    chk("wre_low_cycles", 32'(wlo), wr ? 32'(P - 1) : 32'd0);
                    wlo = 0;
                end
            end else begin
                chk("if_ack", 32'(if_ack), 32'(gi));
                chk("mem_ack", 32'(mem_ack), 32'(!gi));
                chk("if_rdata", if_rdata, exp_if_rd);
                chk("mem_rdata", mem_rdata, exp_mem_rd);
                chk("done_ctrl", 32'({ram_wre, ram_oe, ram_doe}), 32'b110);
                if (gi) begin
                    got = if_rdata;
                    if_req = 1'b0;
                    last_if_ack = cyc;
                end else begin
                    got = mem_rdata;
                    mem_req = 1'b0;
                    last_mem_ack = cyc;
                end
            end
        end
        tick();
        chk("busy_idle", 32'(busy), 32'd0);
        chk("ack_idle", 32'({if_ack, mem_ack}), 32'd0);
        if (wr) chk("sram_word", {sram[a | 18'd1], sram[a]}, wd);
        won_if = gi;
    endtask

    initial begin
        vec_t        vt[7];
        logic        w;
        logic [31:0] g;
        logic        starve_exp[6];
        int          wlo;

        vt[0] = '{1'b1, 1'b0, 18'h00011, 32'h0,        32'h12345678};
        vt[1] = '{1'b0, 1'b1, 18'h00020, 32'hDEADBEEF, 32'h0};
        vt[2] = '{1'b0, 1'b0, 18'h00020, 32'h0,        32'hDEADBEEF};
        vt[3] = '{1'b0, 1'b0, 18'h00021, 32'h0,        32'hDEADBEEF};
        vt[4] = '{1'b0, 1'b1, 18'h3FFFF, 32'hA5A55A5A, 32'h0};
        vt[5] = '{1'b1, 1'b0, 18'h3FFFE, 32'h0,        32'hA5A55A5A};
        vt[6] = '{1'b1, 1'b0, 18'h00021, 32'h0,        32'hDEADBEEF};
        starve_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_rw = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        p3_mem_req = 1'b0; p3_mem_rw = 1'b0; p3_mem_addr = '0; p3_mem_wdata = '0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        consec_m = 0; exp_if_rd = 32'h0; exp_mem_rd = 32'h0;
        last_if_ack = 0; last_mem_ack = 0;

        for (int i = 0; i < 256; i++) begin
            pre_we = 1'b1;
            pre_a  = 18'(i);
            pre_d  = init_val(i);
            ref_mem[i] = init_val(i);
            tick();
        end
        pre_we = 1'b0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({if_ack, mem_ack}), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_dout", 32'(ram_dout), 32'h0);
        chk("rst_ctrl", 32'({ram_wre, ram_oe, ram_doe}), 32'b110);
        reset = 1'b1;
        tick();
        chk("idle_no_req", 32'({busy, if_ack, mem_ack}), 32'd0);

        // directed table
        for (int i = 0; i < 7; i++) begin
            if (vt[i].is_if) begin
                if_req = 1'b1; if_addr = vt[i].addr;
            end else begin
                mem_req = 1'b1; mem_rw = vt[i].rw; mem_addr = vt[i].addr; mem_wdata = vt[i].wdata;
            end
            transact(w, g);
            chk("tbl_winner", 32'(w), 32'(vt[i].is_if));
            if (!vt[i].rw) chk("tbl_rdata", g, vt[i].exp);
        end

        // simultaneous requests: MEM first, IF exactly one access later
        if_req = 1'b1; if_addr = 18'h00010;
        mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 18'h00020;
        transact(w, g);
        chk("sim_first_mem", 32'(w), 32'd0);
        transact(w, g);
        chk("sim_then_if", 32'(w), 32'd1);
        chk("sim_if_data", g, 32'h12345678);
        chk("sim_ack_gap", 32'(last_if_ack - last_mem_ack), 32'(2 * P + 2));

        // starvation: MEM held continuously, IF held
        if_req = 1'b1; if_addr = 18'h00011;
        for (int i = 0; i < 6; i++) begin
            if (!mem_req) begin
                mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 18'(8 * i);
            end
            transact(w, g);
            chk("starve_winner", 32'(w), 32'(starve_exp[i]));
        end

        // reset during the high-half write phase
        mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 18'h00300; mem_wdata = 32'h11223344;
        for (int i = 0; i <= P; i++) tick();
        chk("rmw_busy_before", 32'(busy), 32'd1);
        mem_req = 1'b0;
        reset = 1'b0;
        tick();
        chk("rmw_wre", 32'(ram_wre), 32'd1);
        chk("rmw_doe", 32'(ram_doe), 32'd0);
        chk("rmw_busy", 32'(busy), 32'd0);
        chk("rmw_rdata", {if_rdata[15:0], mem_rdata[15:0]}, 32'h0);
        chk("rmw_rdata_hi", {if_rdata[31:16], mem_rdata[31:16]}, 32'h0);
        reset = 1'b1;
        consec_m = 0; exp_if_rd = 32'h0; exp_mem_rd = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rmw_no_ack", 32'({if_ack, mem_ack, busy}), 32'd0);
        end

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            if (!if_req && ($urandom_range(1, 0) == 1)) begin
                if_req = 1'b1; if_addr = 18'($urandom_range(255, 0));
            end
            if (!mem_req && ($urandom_range(1, 0) == 1)) begin
                mem_req = 1'b1; mem_rw = 1'($urandom_range(1, 0));
                mem_addr = 18'($urandom_range(255, 0)); mem_wdata = $urandom;
            end
            if (!if_req && !mem_req) begin
                tick();
                chk("rnd_idle", 32'({busy, if_ack, mem_ack}), 32'd0);
            end else begin
                transact(w, g);
            end
        end

        // PHASE=3 instance: write then read with capture timing
        p3_mem_req = 1'b1; p3_mem_rw = 1'b1; p3_mem_addr = 18'h00040; p3_mem_wdata = 32'hCAFEF00D;
        wlo = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c <= 6 && !p3_ram_wre) wlo++;
            if (c == 3 || c == 6) begin
                chk("p3_wre_low", 32'(wlo), 32'd2);
                wlo = 0;
            end
            chk("p3_wr_ack", 32'(p3_mem_ack), 32'(c == 7));
            if (c == 7) p3_mem_req = 1'b0;
        end
        chk("p3_sram", {sram3[8'h41], sram3[8'h40]}, 32'hCAFEF00D);
        p3_mem_req = 1'b1; p3_mem_rw = 1'b0; p3_mem_addr = 18'h00041;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 3) chk("p3_rd_lo_pending", p3_mem_rdata, 32'h0);
            if (c == 4) chk("p3_rd_lo_cap", p3_mem_rdata, 32'h0000F00D);
            if (c == 6) chk("p3_rd_hi_pending", p3_mem_rdata, 32'h0000F00D);
            if (c == 7) begin
                chk("p3_rd_ack", 32'(p3_mem_ack), 32'd1);
                chk("p3_rd_data", p3_mem_rdata, 32'hCAFEF00D);
                p3_mem_req = 1'b0;
            end
        end
        tick();
        chk("p3_idle", 32'({p3_busy, p3_mem_ack, p3_if_ack}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single 16-bit asynchronous SRAM between the pipeline's two 32-bit requesters: instruction fetch (read-only) and the memory stage (read/write). Each granted 32-bit access is sequenced as two 16-bit SRAM phases, low half then high half, and completed with a one-cycle acknowledge. The block sits between the Fetch/Memory stages and the board SRAM pins, under the system clock (not the divided pipeline clock).

## Interface

- `PHASE`, default 2: cycles per 16-bit SRAM phase; legal values are 2 or more.
- `MAX_CONSEC`, default 4: maximum consecutive MEM grants while IF waits before IF is forced through; legal values are 1 or more.

- `clock`: in, 1. System clock. **One clock; all logic is synchronous to it.**
- `reset`: in, 1. **Synchronous, active-low reset.**
- `if_req`: in, 1. Fetch read request. Held until `if_ack`.
- `if_addr`: in, 18. Fetch halfword address. Bit 0 is ignored.
- `if_ack`: out, 1. One-cycle pulse; `if_rdata` is valid while it is high.
- `if_rdata`: out, 32. Fetch read data, registered. Held until the next IF completion.
- `mem_req`: in, 1. Memory-stage request. Held until `mem_ack`.
- `mem_rw`: in, 1. 1 = write, 0 = read.
- `mem_addr`: in, 18. Halfword address. Bit 0 is ignored.
- `mem_wdata`: in, 32. Write data.
- `mem_ack`: out, 1. One-cycle completion pulse.
- `mem_rdata`: out, 32. Read data, registered. Held until the next MEM read completion.
- `ram_addr`: out, 18. SRAM address.
- `ram_dout`: out, 16. SRAM write data.
- `ram_din`: in, 16. SRAM read data. The top level builds the tristate from `ram_dout`/`ram_doe`.
- `ram_doe`: out, 1. 1 = drive `ram_dout` onto the SRAM bus.
- `ram_wre`: out, 1. SRAM write enable, active-low.
- `ram_oe`: out, 1. SRAM output enable, active-low.
- `busy`: out, 1. High in every state except IDLE.

## Operation

**States:** IDLE, LO, HI, DONE.

**IDLE**
- Samples requests. If neither is pending, it stays in IDLE.
- Arbitration:
  - MEM has priority.
  - Exception: when `if_req` is high and `consec == MAX_CONSEC`, IF is granted.
- On a grant:
  - Latch the owner, rw, `{addr[17:1],1'b0}` and the write data.
  - Go to LO.
- `consec` counter, width `$clog2(MAX_CONSEC+1)`:
  - Increments on a MEM grant while `if_req` is high.
  - Clears on an IF grant.
  - Clears on a MEM grant while `if_req` is low.
  - Saturates at `MAX_CONSEC`.

**LO, then HI**
- Each state lasts `PHASE` cycles, timed by a phase counter.
- LO accesses the even halfword (data bits 15:0). HI accesses `addr|1` (data bits 31:16).
- Read phase:
  - `ram_oe=0`, `ram_doe=0`, `ram_wre=1`.
  - `ram_din` is captured into the matching half of the owner's rdata register on the last cycle of the phase.
- Write phase:
  - `ram_oe=1`, `ram_doe=1`, `ram_dout` holds the half being written for the whole phase.
  - `ram_wre=0` on phase cycles 0 to PHASE-2.
  - `ram_wre=1` on the last cycle, as data/address hold.
- `ram_addr` is stable for the whole phase.

**DONE**
- One cycle. The owner's ack is 1. All SRAM controls are idle.
- The next state is always IDLE. Requests are not sampled in DONE.

**Idle SRAM outputs:** `ram_wre=1`, `ram_oe=1`, `ram_doe=0`. `ram_addr` and `ram_dout` hold their last values.

**Requester rule**
- A requester deasserts `req` in the cycle after its ack.
- A `req` still high in IDLE after DONE is treated as a new request.
- Requester inputs are ignored outside IDLE, because they are latched at grant.

**Address bit 0**
- Bit 0 of the request address is ignored.
- Word address = `addr[17:1]`.

## Timing

- Let the request be high in IDLE during cycle T.
  - LO occupies T+1 to T+PHASE.
  - HI occupies T+PHASE+1 to T+2·PHASE.
  - The ack is high in cycle T+2·PHASE+1.
  - IDLE returns at T+2·PHASE+2.
- With `PHASE=2`, the ack comes 5 cycles after the grant cycle. Back-to-back throughput is one access per 2·PHASE+2 cycles.
- rdata updates:
  - Low half: at the edge ending the last LO cycle.
  - High half: at the edge ending the last HI cycle.
  - Both halves are valid when the ack is seen.
- The ack is never high for both requesters in the same cycle.
- Simultaneous `if_req` and `mem_req` in IDLE: MEM wins unless the starvation limit has been hit.

**Reset values** (reset=0 at a clock edge):
- state = IDLE
- `if_ack = mem_ack = 0`
- `if_rdata = mem_rdata = 0`
- `ram_addr = 0`, `ram_dout = 0`, `ram_doe = 0`
- `ram_wre = 1`, `ram_oe = 1`
- `busy = 0`
- `consec = 0`, phase counter = 0

**Reset mid-access**
- Abort the access. No ack is issued.
- `ram_wre` goes high at that same edge.
- A partially written word is left as is.

## Test plan

- **IF read:** preload SRAM[0x10]=0x5678 and SRAM[0x11]=0x1234; `if_req` with addr 0x11 -> `ram_addr` is 0x10 for 2 cycles, then 0x11; `if_ack` pulses 5 cycles after the grant with `if_rdata=0x12345678`.
- **MEM write then read:** write 0xDEADBEEF at 0x20 -> `ram_wre` low for 1 of 2 cycles per phase, SRAM[0x20]=0xBEEF and SRAM[0x21]=0xDEAD; read back -> `mem_rdata=0xDEADBEEF`, and `if_rdata` is unchanged.
- **Simultaneous requests:** both requests high in the same IDLE cycle -> `mem_ack` first; `if_ack` exactly 2·PHASE+2 cycles later; no overlap.
- **Starvation:** `mem_req` held continuously (re-raised after each ack) and `if_req` held -> 4 MEM acks, then 1 IF ack, then MEM resumes.
- **Reset mid-write:** assert reset during the HI phase -> `ram_wre=1`, `ram_doe=0`, `busy=0` the next cycle, no ack, both rdata registers are 0.
- **PHASE=3 instance:** MEM write -> `ram_wre` low 2 cycles per phase, ack at T+7, read captures on the 3rd cycle of each phase.
